// File: rtl/ahb_capture_slave_if.sv
// AHB-Lite bus bundle between the MSS fabric master port and the pixel capture slave.
// HREADYIN is the interconnect's view of bus readiness; HREADYOUT is this slave's own ready.
interface ahb_capture_slave_if;
    logic        HSEL;
    logic [3:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYIN;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
        input  HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_capture_slave.sv
// AHB-Lite slave that packs an 8-bit pixel stream into 32-bit words, buffers them in a FIFO
// and lets firmware drain them through CTRL/STATUS/DATA/LINES registers, with a level IRQ.
module ahb_capture_slave #(
    parameter int FIFO_DEPTH = 16,
    parameter int WAIT_MAX   = 15,
    parameter int IRQ_LEVEL  = 8
) (
    input  logic                      FAB_CLK,
    input  logic                      FAB_RESET,
    ahb_capture_slave_if.slave        ahb,
    input  logic                      PIX_VALID,
    input  logic [7:0]                PIX_DATA,
    input  logic                      PIX_EOL,
    output logic                      IRQ
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam logic [AW:0]    DEPTH_C   = FIFO_DEPTH[AW:0];
    localparam logic [WW-1:0]  WAIT_LAST = WW'(WAIT_MAX - 1);
    localparam logic [8:0]     IRQ_THR   = 9'(IRQ_LEVEL);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_DATA   = 2'd2;
    localparam logic [1:0] A_LINES  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t          r_state, w_next;
    logic [1:0]      r_addr;
    logic            r_write;
    logic [WW-1:0]   r_wait;
    logic            r_en, r_clr, r_ovf, r_irq;
    logic [15:0]     r_lines;
    logic [31:0]     r_pack;
    logic [1:0]      r_idx;
    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_accept, w_size_ok, w_hready, w_hresp, w_pop, w_reg_wr;
    logic            w_empty, w_full, w_pix, w_push_req, w_push, w_drop;
    logic [8:0]      w_level;
    logic [31:0]     w_word, w_rdata;
    logic            w_unused_bits;

    assign w_accept   = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADYIN;
    assign w_size_ok  = (ahb.HSIZE == 3'b010);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == DEPTH_C);
    assign w_level    = 9'(r_count);
    assign w_unused_bits = ^{ahb.HADDR[1:0], ahb.HTRANS[0], ahb.HWDATA[31:3], w_level[8]};

    // Data-phase FSM: decides ready/response and whether this cycle pops or writes a register.
    always_comb begin
        w_next   = r_state;
        w_hready = 1'b1;
        w_hresp  = 1'b0;
        w_pop    = 1'b0;
        w_reg_wr = 1'b0;
        case (r_state)
            S_DATA: begin
                if (r_write) begin
                    w_reg_wr = 1'b1;
                end else if (r_addr == A_DATA) begin
                    if (w_empty) begin
                        w_hready = 1'b0;
                        w_next   = (WAIT_MAX <= 1) ? S_ERR1 : S_WAIT;
                    end else begin
                        w_pop = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                end else begin
                    w_hready = 1'b0;
                    if (r_wait == WAIT_LAST) w_next = S_ERR1;
                end
            end
            S_ERR1: begin
                w_hready = 1'b0;
                w_hresp  = 1'b1;
                w_next   = S_ERR2;
            end
            S_ERR2:  w_hresp = 1'b1;
            default: ;
        endcase
        // A completing data phase overlaps the next address phase.
        if (w_hready) w_next = w_accept ? (w_size_ok ? S_DATA : S_ERR1) : S_IDLE;
    end

    // NOTE: every sequential process uses <= so all registers update from the same pre-edge values.
    always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
        if (FAB_RESET) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (w_hready && w_accept) begin
                r_addr  <= ahb.HADDR[3:2];
                r_write <= ahb.HWRITE;
            end
            if (r_state == S_DATA)      r_wait <= WW'(1);
            else if (r_state == S_WAIT) r_wait <= r_wait + 1'b1;
        end
    end

    always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
        if (FAB_RESET) begin
            r_en  <= 1'b0;
            r_clr <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_clr <= w_reg_wr && (r_addr == A_CTRL) && ahb.HWDATA[1];
            if (w_reg_wr && (r_addr == A_CTRL)) r_en <= ahb.HWDATA[0];
            r_irq <= r_en & ((w_level >= IRQ_THR) | r_ovf);
        end
    end

    // Pixel packer: byte n lands in bits [8n+7:8n]; a full word or EOL pushes.
    assign w_pix      = PIX_VALID & r_en;
    assign w_push_req = w_pix & (PIX_EOL | (r_idx == 2'd3));
    assign w_push     = w_push_req & (~w_full | w_pop) & ~r_clr;
    assign w_drop     = w_push_req & w_full & ~w_pop;

    always_comb begin
        w_word = r_pack;
        case (r_idx)
            2'd0: w_word[7:0]   = PIX_DATA;
            2'd1: w_word[15:8]  = PIX_DATA;
            2'd2: w_word[23:16] = PIX_DATA;
            2'd3: w_word[31:24] = PIX_DATA;
        endcase
    end

    always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
        if (FAB_RESET) begin
            r_pack  <= '0;
            r_idx   <= '0;
            r_lines <= '0;
            r_ovf   <= 1'b0;
        end else if (r_clr) begin
            r_pack  <= '0;
            r_idx   <= '0;
            r_lines <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_pix) begin
                if (w_push_req) begin
                    r_pack <= '0;
                    r_idx  <= '0;
                end else begin
                    r_pack <= w_word;
                    r_idx  <= r_idx + 1'b1;
                end
                if (PIX_EOL) r_lines <= r_lines + 1'b1;
            end
            if (w_drop)
                r_ovf <= 1'b1;
            else if (w_reg_wr && (r_addr == A_STATUS) && ahb.HWDATA[2])
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge FAB_CLK or posedge FAB_RESET) begin
        if (FAB_RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (r_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge FAB_CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= w_word;
    end

    always_comb begin
        w_rdata = '0;
        if (((r_state == S_DATA) || (r_state == S_WAIT)) && !r_write) begin
            case (r_addr)
                A_CTRL:   w_rdata = {31'b0, r_en};
                A_STATUS: w_rdata = {16'b0, w_level[7:0], 5'b0, r_ovf, w_full, w_empty};
                A_DATA:   if (!w_empty) w_rdata = r_mem[r_rd_ptr];
                A_LINES:  w_rdata = {16'b0, r_lines};
            endcase
        end
    end

    assign ahb.HREADYOUT = w_hready;
    assign ahb.HRESP     = w_hresp;
    assign ahb.HRDATA    = w_rdata;
    assign IRQ           = r_irq;

endmodule

// File: tb/tb_ahb_capture_slave.sv
// Self-checking bench for ahb_capture_slave: register table, then wait/error/overflow/reset sequences.
// Read expectations are queued as transfers are issued and compared when each data phase completes.
module tb_ahb_capture_slave;

  logic       FAB_CLK = 1'b0;
  logic       FAB_RESET = 1'b0;
  logic       PIX_VALID, PIX_EOL, IRQ;
  logic [7:0] PIX_DATA;

  ahb_capture_slave_if bus();
  assign bus.HREADYIN = bus.HREADYOUT;

  ahb_capture_slave #(.FIFO_DEPTH(16), .WAIT_MAX(15), .IRQ_LEVEL(8)) dut (
    .FAB_CLK   (FAB_CLK),
    .FAB_RESET (FAB_RESET),
    .ahb       (bus),
    .PIX_VALID (PIX_VALID),
    .PIX_DATA  (PIX_DATA),
    .PIX_EOL   (PIX_EOL),
    .IRQ       (IRQ)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_waits;
  } xfer_t;

  typedef struct {
    int          nbytes;
    logic [31:0] bytes;
    logic        eol;
    xfer_t       x;
  } vec_t;

  xfer_t stim_q[$];
  xfer_t sb_q[$];
  vec_t  vecs[$];
  int    n_checks = 0;
  int    n_err = 0;
  int    bus_cycles = 0;
  string tag = "init";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got 0x%08h expected 0x%08h", tag, name, act, exp);
    end
  endtask

  function automatic xfer_t mk(input logic wr, input logic [3:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata, input logic [31:0] exp,
                               input logic err, input int waits);
    xfer_t t;
    t.wr = wr; t.addr = addr; t.size = size; t.wdata = wdata;
    t.exp_rdata = exp; t.exp_err = err; t.exp_waits = waits;
    return t;
  endfunction

  function automatic xfer_t rd(input logic [3:0] addr, input logic [31:0] exp);
    return mk(1'b0, addr, 3'b010, 32'h0, exp, 1'b0, 0);
  endfunction

  function automatic xfer_t wr(input logic [3:0] addr, input logic [31:0] data);
    return mk(1'b1, addr, 3'b010, data, 32'h0, 1'b0, 0);
  endfunction

  function automatic vec_t mkv(input int n, input logic [31:0] b, input logic eol, input xfer_t x);
    vec_t v;
    v.nbytes = n; v.bytes = b; v.eol = eol; v.x = x;
    return v;
  endfunction

  function automatic logic [31:0] pix_word(input int w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = 8'(4*w + k);
    return r;
  endfunction

  // Pipelined master: issues stim_q, completes sb_q; every task starts and ends at posedge+1.
  task automatic run_bus();
    int    waits = 0;
    int    errlow = 0;
    int    guard = 0;
    xfer_t e;
    while ((stim_q.size() != 0 || sb_q.size() != 0) && guard < 400) begin
      bus.HWDATA = (sb_q.size() != 0) ? sb_q[0].wdata : 32'h0;
      if (stim_q.size() != 0) begin
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = stim_q[0].addr;
        bus.HWRITE = stim_q[0].wr; bus.HSIZE = stim_q[0].size;
      end else begin
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
      end
      @(negedge FAB_CLK);
      if (sb_q.size() != 0) begin
        if (!bus.HREADYOUT) begin
          if (bus.HRESP) errlow++;
          else waits++;
        end else begin
          e = sb_q.pop_front();
          check("hrdata", bus.HRDATA, e.exp_rdata);
          check("hresp", 32'(bus.HRESP), 32'(e.exp_err));
          check("err_cycle1", errlow, e.exp_err ? 1 : 0);
          check("wait_states", waits, e.exp_waits);
          waits = 0;
          errlow = 0;
        end
      end
      if (bus.HREADYOUT && stim_q.size() != 0) sb_q.push_back(stim_q.pop_front());
      @(posedge FAB_CLK); #1;
      guard++;
    end
    bus_cycles = guard;
    if (stim_q.size() != 0 || sb_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s bus_timeout: got %0d pending expected 0", tag, stim_q.size() + sb_q.size());
      stim_q.delete();
      sb_q.delete();
    end
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = 32'h0;
    repeat (2) @(posedge FAB_CLK);
    #1;
  endtask

  task automatic feed(input int n, input logic [31:0] b, input logic eol);
    for (int i = 0; i < n; i++) begin
      PIX_VALID = 1'b1;
      PIX_DATA  = b[8*i +: 8];
      PIX_EOL   = eol && (i == n - 1);
      @(posedge FAB_CLK); #1;
    end
    PIX_VALID = 1'b0;
    PIX_EOL   = 1'b0;
    @(posedge FAB_CLK); #1;
  endtask

  task automatic one(input xfer_t x);
    stim_q.push_back(x);
    run_bus();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PIX_VALID = 1'b0; PIX_EOL = 1'b0; PIX_DATA = 8'h0;
    bus.HSEL = 1'b0; bus.HADDR = 4'h0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'b010; bus.HWDATA = 32'h0;

    // Reset values, visible while reset is held.
    #1 FAB_RESET = 1'b1;
    #1;
    tag = "reset";
    check("hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("hresp", 32'(bus.HRESP), 32'd0);
    check("hrdata", bus.HRDATA, 32'h0);
    check("irq", 32'(IRQ), 32'd0);
    repeat (3) @(posedge FAB_CLK);
    #1 FAB_RESET = 1'b0;
    @(posedge FAB_CLK); #1;
    stim_q.push_back(rd(4'h0, 32'h0));
    stim_q.push_back(rd(4'h4, 32'h1));
    stim_q.push_back(rd(4'hC, 32'h0));
    run_bus();

    // Register table: optional pixel bytes, then one transfer.
    vecs.push_back(mkv(0, 32'h0,        1'b0, wr(4'h0, 32'h1)));
    vecs.push_back(mkv(4, 32'h44332211, 1'b0, rd(4'h4, 32'h0000_0100)));
    vecs.push_back(mkv(0, 32'h0,        1'b0, rd(4'h8, 32'h4433_2211)));
    vecs.push_back(mkv(0, 32'h0,        1'b0, rd(4'h4, 32'h0000_0001)));
    vecs.push_back(mkv(2, 32'h0000BBAA, 1'b1, rd(4'h8, 32'h0000_BBAA)));
    vecs.push_back(mkv(0, 32'h0,        1'b0, rd(4'hC, 32'h0000_0001)));
    vecs.push_back(mkv(0, 32'h0,        1'b0, rd(4'h0, 32'h0000_0001)));
    vecs.push_back(mkv(4, 32'hDEADBEEF, 1'b0, wr(4'h0, 32'h3)));
    vecs.push_back(mkv(0, 32'h0,        1'b0, rd(4'hC, 32'h0000_0000)));
    vecs.push_back(mkv(0, 32'h0,        1'b0, rd(4'h4, 32'h0000_0001)));
    vecs.push_back(mkv(0, 32'h0,        1'b0, wr(4'h4, 32'hFFFF_FFFF)));
    vecs.push_back(mkv(4, 32'h0D0C0B0A, 1'b0, wr(4'h8, 32'h1234_5678)));
    vecs.push_back(mkv(0, 32'h0,        1'b0, rd(4'h4, 32'h0000_0100)));
    vecs.push_back(mkv(0, 32'h0,        1'b0, mk(1'b1, 4'h0, 3'b001, 32'h0, 32'h0, 1'b1, 0)));
    vecs.push_back(mkv(0, 32'h0,        1'b0, rd(4'h0, 32'h0000_0001)));
    vecs.push_back(mkv(0, 32'h0,        1'b0, mk(1'b0, 4'h4, 3'b000, 32'h0, 32'h0, 1'b1, 0)));
    vecs.push_back(mkv(0, 32'h0,        1'b0, rd(4'h8, 32'h0D0C_0B0A)));
    vecs.push_back(mkv(0, 32'h0,        1'b0, rd(4'h4, 32'h0000_0001)));
    for (int i = 0; i < vecs.size(); i++) begin
      tag = $sformatf("vec%0d", i);
      if (vecs[i].nbytes != 0) feed(vecs[i].nbytes, vecs[i].bytes, vecs[i].eol);
      one(vecs[i].x);
    end

    // LINES wraps from 0xFFFF to 0.
    tag = "lines_wrap";
    PIX_VALID = 1'b1; PIX_EOL = 1'b1; PIX_DATA = 8'h5A;
    repeat (65535) @(posedge FAB_CLK);
    #1;
    PIX_VALID = 1'b0; PIX_EOL = 1'b0;
    @(posedge FAB_CLK); #1;
    one(rd(4'hC, 32'h0000_FFFF));
    feed(1, 32'h5A, 1'b1);
    one(rd(4'hC, 32'h0000_0000));
    one(wr(4'h0, 32'h3));
    one(rd(4'h4, 32'h0000_0001));

    // Empty-FIFO DATA read, completed by a word arriving during the wait.
    tag = "wait_push";
    feed(3, 32'h00030201, 1'b0);
    stim_q.push_back(mk(1'b0, 4'h8, 3'b010, 32'h0, 32'h0403_0201, 1'b0, 6));
    fork
      run_bus();
      begin
        repeat (6) @(posedge FAB_CLK);
        #1;
        PIX_VALID = 1'b1; PIX_DATA = 8'h04;
        @(posedge FAB_CLK); #1;
        PIX_VALID = 1'b0;
      end
    join

    // Empty-FIFO DATA read that times out into the ERROR pair.
    tag = "wait_timeout";
    one(mk(1'b0, 4'h8, 3'b010, 32'h0, 32'h0, 1'b1, 15));

    // Overflow, W1C, and IRQ falling once the level drops below the threshold.
    tag = "overflow";
    for (int w = 0; w < 17; w++) feed(4, pix_word(w), 1'b0);
    check("irq_full", 32'(IRQ), 32'd1);
    one(rd(4'h4, 32'h0000_1006));
    one(wr(4'h4, 32'h0000_0004));
    one(rd(4'h4, 32'h0000_1002));
    check("irq_after_w1c", 32'(IRQ), 32'd1);
    for (int w = 0; w < 8; w++) stim_q.push_back(rd(4'h8, pix_word(w)));
    run_bus();
    check("irq_level8", 32'(IRQ), 32'd1);
    one(rd(4'h8, pix_word(8)));
    check("irq_level7", 32'(IRQ), 32'd0);

    // Back-to-back zero-wait reads.
    tag = "b2b";
    stim_q.push_back(rd(4'h4, 32'h0000_0700));
    stim_q.push_back(rd(4'h8, pix_word(9)));
    stim_q.push_back(rd(4'hC, 32'h0000_0000));
    run_bus();
    check("bus_cycles", bus_cycles, 4);

    // Reset asserted while a DATA read is waiting.
    tag = "reset_in_wait";
    one(wr(4'h0, 32'h3));
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 4'h8; bus.HWRITE = 1'b0; bus.HSIZE = 3'b010;
    @(posedge FAB_CLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    repeat (3) @(negedge FAB_CLK);
    check("hreadyout_waiting", 32'(bus.HREADYOUT), 32'd0);
    #1 FAB_RESET = 1'b1;
    #1;
    check("hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("hresp", 32'(bus.HRESP), 32'd0);
    check("irq", 32'(IRQ), 32'd0);
    check("hrdata", bus.HRDATA, 32'h0);
    @(posedge FAB_CLK); #1;
    FAB_RESET = 1'b0;
    @(posedge FAB_CLK); #1;
    one(rd(4'h4, 32'h0000_0001));
    one(rd(4'h0, 32'h0000_0000));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
